// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: FSM state encoding, Zicsr
// funct3 codes and the CSR index map, plus small decode helpers.
package csr_access_unit_pkg;

    // FSM states of the access sequencer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } csr_state_e;

    // Zicsr funct3 encodings.
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // CSR index definitions.
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_CUSTOM0  = 12'h800;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;

    // funct3 low bits 00 (000 and 100) are not Zicsr operations.
    function automatic logic funct3_legal(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

    // RW/RWI: the plain-write forms, which never suppress their write.
    function automatic logic funct3_is_rw(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/csr_access_unit.sv
// Zicsr execution unit: fixed IDLE->READ->WRITE->DONE sequence that reads a
// CSR, applies RW/RS/RC (or immediate) modification and writes it back.
// Optional build macro CSR_READONLY_CHECK_EN: when defined, a non-suppressed
// write to a CSR whose top index bits are 2'b11 (read-only space) is rejected
// as illegal with no CSR access at all.
// Handshake: start is a single-cycle request honoured only while busy is low;
// done/illegal/rd_write/rd_data form a one-cycle response with no backpressure.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int CSR_INDEX_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 funct3,
    input  logic [CSR_INDEX_WIDTH-1:0] csr_index,
    input  logic [4:0]                 rs1_index,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [4:0]                 rd_index,
    output logic                       busy,
    output logic                       csr_read_enable,
    output logic [CSR_INDEX_WIDTH-1:0] csr_read_index,
    input  logic [XLEN-1:0]            csr_read_data,
    output logic                       csr_write_enable,
    output logic [CSR_INDEX_WIDTH-1:0] csr_write_index,
    output logic [XLEN-1:0]            csr_write_data,
    output logic                       done,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_write,
    output logic                       illegal,
    output csr_state_e                 dbg_state_o
);

    csr_state_e                 state_q, state_d;
    logic [2:0]                 funct3_q, funct3_d;
    logic [CSR_INDEX_WIDTH-1:0] csr_q, csr_d;
    logic [4:0]                 rs1i_q, rs1i_d;
    logic [XLEN-1:0]            rs1d_q, rs1d_d;
    logic [4:0]                 rd_q, rd_d;
    logic                       illeg_q, illeg_d;
    logic [XLEN-1:0]            old_q, old_d;
    logic                       busy_q, busy_d;
    logic                       rd_en_q, rd_en_d;
    logic                       wr_en_q, wr_en_d;
    logic [XLEN-1:0]            wr_data_q, wr_data_d;
    logic                       done_q, done_d;
    logic [XLEN-1:0]            rd_data_q, rd_data_d;
    logic                       rd_write_q, rd_write_d;
    logic                       illegal_q, illegal_d;

    logic                       in_wants_write;
    logic                       in_ro_hit;
    logic                       in_illegal;
    logic [XLEN-1:0]            operand;
    logic                       lat_wants_write;

    // Decode of the incoming request, used only at acceptance.
    always_comb begin
        in_wants_write = funct3_is_rw(funct3) || (rs1_index != 5'd0);
`ifdef CSR_READONLY_CHECK_EN
        // Read-only CSRs occupy the top quarter of the index space.
        in_ro_hit = (csr_index[CSR_INDEX_WIDTH-1 -: 2] == 2'b11) && in_wants_write;
`else
        in_ro_hit = 1'b0;
`endif
        in_illegal = !funct3_legal(funct3) || in_ro_hit;
    end

    // Operand selection and write suppression on the latched instruction.
    always_comb begin
        operand         = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1i_q} : rs1d_q;
        lat_wants_write = funct3_is_rw(funct3_q) || (rs1i_q != 5'd0);
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        csr_d      = csr_q;
        rs1i_d     = rs1i_q;
        rs1d_d     = rs1d_q;
        rd_d       = rd_q;
        illeg_d    = illeg_q;
        old_d      = old_q;
        busy_d     = busy_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_write_d = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_READ;
                    busy_d   = 1'b1;
                    funct3_d = funct3;
                    csr_d    = csr_index;
                    rs1i_d   = rs1_index;
                    rs1d_d   = rs1_data;
                    rd_d     = rd_index;
                    illeg_d  = in_illegal;
                    // A plain write to x0 has no use for the old value.
                    rd_en_d  = !in_illegal && !(funct3_is_rw(funct3) && rd_index == 5'd0);
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
                old_d   = rd_en_q ? csr_read_data : '0;
                case (funct3_q[1:0])
                    2'b10:   wr_data_d = old_d | operand;
                    2'b11:   wr_data_d = old_d & ~operand;
                    default: wr_data_d = operand;
                endcase
                wr_en_d = !illeg_q && lat_wants_write;
            end
            ST_WRITE: begin
                state_d    = ST_DONE;
                done_d     = 1'b1;
                rd_data_d  = old_q;
                rd_write_d = !illeg_q && (rd_q != 5'd0);
                illegal_d  = illeg_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latched fields and all outputs; reset aborts any sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            funct3_q   <= '0;
            csr_q      <= '0;
            rs1i_q     <= '0;
            rs1d_q     <= '0;
            rd_q       <= '0;
            illeg_q    <= 1'b0;
            old_q      <= '0;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_write_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            csr_q      <= csr_d;
            rs1i_q     <= rs1i_d;
            rs1d_q     <= rs1d_d;
            rd_q       <= rd_d;
            illeg_q    <= illeg_d;
            old_q      <= old_d;
            busy_q     <= busy_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_write_q <= rd_write_d;
            illegal_q  <= illegal_d;
        end
    end

    assign busy             = busy_q;
    assign csr_read_enable  = rd_en_q;
    assign csr_read_index   = csr_q;
    assign csr_write_enable = wr_en_q;
    assign csr_write_index  = csr_q;
    assign csr_write_data   = wr_data_q;
    assign done             = done_q;
    assign rd_data          = rd_data_q;
    assign rd_write         = rd_write_q;
    assign illegal          = illegal_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: CSR file model, transaction-level
// reference model checked every cycle, directed cases and random traffic.
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [11:0] csr_index = 12'd0;
    logic [4:0]  rs1_index = 5'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [4:0]  rd_index = 5'd0;
    logic        busy, csr_read_enable, csr_write_enable, done, rd_write, illegal;
    logic [11:0] csr_read_index, csr_write_index;
    logic [31:0] csr_read_data, csr_write_data, rd_data;
    csr_state_e  dbg_state;

    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0 idle, 1..3 cycles after acceptance.
    int          phase = 0;
    logic        e_legal, e_rd, e_wr, e_rdw;
    logic [11:0] e_idx;
    logic [31:0] e_old, e_new;
    int          obs_rd = 0, obs_wr = 0, obs_done = 0;
    logic [31:0] obs_wdata = 32'd0;

    csr_access_unit #(.XLEN(32), .CSR_INDEX_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .csr_index(csr_index), .rs1_index(rs1_index), .rs1_data(rs1_data),
        .rd_index(rd_index), .busy(busy), .csr_read_enable(csr_read_enable),
        .csr_read_index(csr_read_index), .csr_read_data(csr_read_data),
        .csr_write_enable(csr_write_enable), .csr_write_index(csr_write_index),
        .csr_write_data(csr_write_data), .done(done), .rd_data(rd_data),
        .rd_write(rd_write), .illegal(illegal), .dbg_state_o(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // CSR register file: combinational read, write on clock edge.
    assign csr_read_data = mem[csr_read_index];
    always @(posedge clk) begin
        if (csr_write_enable) mem[csr_write_index] <= csr_write_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: advance the model for the edge just passed, then check.
    always @(negedge clk) begin
        logic [2:0]  f3;
        logic        isrw, wants;
        logic [31:0] op;
        if (reset) begin
            phase = 0;
            chk("rst_busy", busy, 0);
            chk("rst_rd_en", csr_read_enable, 0);
            chk("rst_wr_en", csr_write_enable, 0);
            chk("rst_done", done, 0);
            chk("rst_illegal", illegal, 0);
            chk("rst_rd_write", rd_write, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_wr_data", csr_write_data, 0);
        end else begin
            if (phase == 0) begin
                if (start) begin
                    f3    = funct3;
                    isrw  = (f3[1:0] == 2'b01);
                    wants = isrw || (rs1_index != 5'd0);
                    e_legal = (f3[1:0] != 2'b00);
`ifdef CSR_READONLY_CHECK_EN
                    if (csr_index[11:10] == 2'b11 && wants) e_legal = 1'b0;
`endif
                    e_rd  = e_legal && !(isrw && rd_index == 5'd0);
                    e_wr  = e_legal && wants;
                    e_rdw = e_legal && (rd_index != 5'd0);
                    e_idx = csr_index;
                    op    = f3[2] ? {27'd0, rs1_index} : rs1_data;
                    e_old = e_rd ? mem[csr_index] : 32'd0;
                    if (isrw)                 e_new = op;
                    else if (f3[1:0] == 2'b10) e_new = e_old | op;
                    else                      e_new = e_old & ~op;
                    phase = 1;
                end
            end else if (phase == 3) begin
                phase = 0;
            end else begin
                phase = phase + 1;
            end
            chk("busy", busy, phase != 0);
            chk("rd_en", csr_read_enable, phase == 1 && e_rd);
            chk("wr_en", csr_write_enable, phase == 2 && e_wr);
            chk("done", done, phase == 3);
            chk("illegal", illegal, phase == 3 && !e_legal);
            chk("rd_write", rd_write, phase == 3 && e_rdw);
            if (csr_read_enable) chk("rd_index", csr_read_index, e_idx);
            if (csr_write_enable) begin
                chk("wr_index", csr_write_index, e_idx);
                chk("wr_data", csr_write_data, e_new);
            end
            if (done) chk("rd_data", rd_data, e_old);
        end
        if (csr_read_enable) obs_rd++;
        if (csr_write_enable) begin
            obs_wr++;
            obs_wdata = csr_write_data;
        end
        if (done) obs_done++;
    end

    // Drive one instruction and wait (bounded) for its completion pulse.
    task automatic run_op(input logic [2:0] f3, input logic [11:0] idx,
                          input logic [4:0] r1i, input logic [31:0] r1d,
                          input logic [4:0] rd, input logic poke,
                          output logic [31:0] o_rd_data, output logic o_ill,
                          output logic o_rdw);
        int n;
        @(negedge clk); #1;
        funct3 = f3; csr_index = idx; rs1_index = r1i; rs1_data = r1d; rd_index = rd;
        start = 1'b1;
        @(negedge clk); #1;
        start = poke;
        funct3 = 3'($urandom_range(0, 7));
        csr_index = 12'($urandom_range(0, 4095));
        rs1_index = 5'($urandom_range(0, 31));
        rs1_data = $urandom;
        rd_index = 5'($urandom_range(0, 31));
        n = 0;
        while (!done && n < 8) begin
            @(negedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        o_rd_data = rd_data;
        o_ill = illegal;
        o_rdw = rd_write;
        @(negedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic        ill, rdw;
        int          r0, w0, d0;
        logic [11:0] idx;
        logic [4:0]  r1i, rd;

        for (int i = 0; i < 4096; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1 chk("post_reset_busy", busy, 0);

        // CSRRS to B00: old 0x10 | 3 -> 0x13.
        mem[12'hB00] = 32'h0000_0010;
        r0 = obs_rd; w0 = obs_wr;
        run_op(F3_CSRRS, 12'hB00, 5'd9, 32'h0000_0003, 5'd5, 1'b0, r, ill, rdw);
        chk("rs_rd_data", r, 32'h10);
        chk("rs_rd_write", rdw, 1);
        chk("rs_illegal", ill, 0);
        chk("rs_reads", obs_rd - r0, 1);
        chk("rs_writes", obs_wr - w0, 1);
        chk("rs_wdata", obs_wdata, 32'h13);
        chk("rs_mem", mem[12'hB00], 32'h13);

        // CSRRWI to 800 with rd=0: no read, writes zimm 7.
        r0 = obs_rd; w0 = obs_wr;
        run_op(F3_CSRRWI, 12'h800, 5'd7, 32'hFFFF_FFFF, 5'd0, 1'b0, r, ill, rdw);
        chk("rwi_reads", obs_rd - r0, 0);
        chk("rwi_writes", obs_wr - w0, 1);
        chk("rwi_mem", mem[12'h800], 32'h7);
        chk("rwi_rd_write", rdw, 0);
        chk("rwi_rd_data", r, 0);

        // CSRRC with rs1=x0: read only.
        mem[12'h340] = 32'h0000_00FF;
        r0 = obs_rd; w0 = obs_wr;
        run_op(F3_CSRRC, 12'h340, 5'd0, 32'h0000_000F, 5'd4, 1'b0, r, ill, rdw);
        chk("rc0_reads", obs_rd - r0, 1);
        chk("rc0_writes", obs_wr - w0, 0);
        chk("rc0_rd_data", r, 32'hFF);
        chk("rc0_mem", mem[12'h340], 32'hFF);

        // Illegal funct3 100, with a start pulse while busy.
        r0 = obs_rd; w0 = obs_wr; d0 = obs_done;
        run_op(3'b100, 12'h340, 5'd3, 32'h1, 5'd6, 1'b1, r, ill, rdw);
        chk("ill_reads", obs_rd - r0, 0);
        chk("ill_writes", obs_wr - w0, 0);
        chk("ill_flag", ill, 1);
        chk("ill_rd_write", rdw, 0);
        chk("ill_single_done", obs_done - d0, 1);
        chk("ill_idle_after", busy, 0);

        // CSRRW to read-only space C00.
        mem[12'hC00] = 32'h0000_5555;
        r0 = obs_rd; w0 = obs_wr;
        run_op(F3_CSRRW, 12'hC00, 5'd3, 32'hDEAD_BEEF, 5'd2, 1'b0, r, ill, rdw);
`ifdef CSR_READONLY_CHECK_EN
        chk("ro_illegal", ill, 1);
        chk("ro_reads", obs_rd - r0, 0);
        chk("ro_writes", obs_wr - w0, 0);
        chk("ro_mem", mem[12'hC00], 32'h5555);
`else
        chk("ro_illegal", ill, 0);
        chk("ro_writes", obs_wr - w0, 1);
        chk("ro_mem", mem[12'hC00], 32'hDEAD_BEEF);
        chk("ro_rd_data", r, 32'h5555);
`endif

        // Reset during the WRITE cycle.
        mem[12'h341] = 32'hAAAA_0000;
        d0 = obs_done;
        @(negedge clk); #1;
        funct3 = F3_CSRRW; csr_index = 12'h341; rs1_index = 5'd2;
        rs1_data = 32'h0000_1234; rd_index = 5'd1; start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_wr_before", csr_write_enable, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_wr_fall", csr_write_enable, 0);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", obs_done - d0, 0);
        chk("rst_mid_mem", mem[12'h341], 32'hAAAA_0000);
        run_op(F3_CSRRS, 12'h341, 5'd1, 32'h0000_0001, 5'd3, 1'b0, r, ill, rdw);
        chk("rst_after_rd_data", r, 32'hAAAA_0000);
        chk("rst_after_mem", mem[12'h341], 32'hAAAA_0001);

        // Random traffic against the model.
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 3))
                0:       idx = 12'hC00 | 12'($urandom_range(0, 15));
                1:       idx = 12'($urandom_range(0, 4095));
                2:       idx = CSR_MSCRATCH;
                default: idx = CSR_MCYCLE;
            endcase
            r1i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op(3'($urandom_range(0, 7)), idx, r1i, $urandom, rd,
                   1'($urandom_range(0, 1)), r, ill, rdw);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
